// File: rtl/verificador_paridade_pkg.sv
// rtl/verificador_paridade_pkg.sv - shared constants and helpers for the parity checker
package verificador_paridade_pkg;

  // number of data bits protected by one parity bit
  localparam int DATA_W = 5;

  // parity scheme selectors for ODD_PARITY
  localparam int PAR_EVEN = 0;
  localparam int PAR_ODD  = 1;

  // mismatch rule: the six received bits must XOR to 0 (even) or 1 (odd)
  function automatic logic parity_mismatch(input logic [DATA_W-1:0] data,
                                           input logic bp,
                                           input logic odd_mode);
    return (^data) ^ bp ^ odd_mode;
  endfunction

endpackage

// File: rtl/verificador_paridade_xor.sv
// rtl/verificador_paridade_xor.sv - combinational 6-input parity reduction producing err
module paridade_xor
  import verificador_paridade_pkg::*;
(
  input  logic [DATA_W-1:0] data,
  input  logic              bp,
  input  logic              odd_mode,
  output logic              err
);

  // odd scheme inverts the raw XOR so that a correct word always gives err=0
  always_comb begin
    err = parity_mismatch(data, bp, odd_mode);
  end

endmodule

// File: rtl/verificador_paridade.sv
// rtl/verificador_paridade.sv - registered 5-bit parity checker with error statistics
module verificador_paridade
  import verificador_paridade_pkg::*;
#(
  parameter int ODD_PARITY = PAR_EVEN,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             b1,
  input  logic             b2,
  input  logic             b3,
  input  logic             b4,
  input  logic             b5,
  input  logic             bp,
  input  logic             clr,
  output logic             S,
  output logic             out_valid,
  output logic             err_sticky,
  output logic [CNT_W-1:0] err_cnt
);

  localparam logic             ODD_MODE = (ODD_PARITY != PAR_EVEN);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  logic [DATA_W-1:0] data;
  logic              err;

  // b1 is the MSB of the captured word
  assign data = {b1, b2, b3, b4, b5};

  paridade_xor u_xor (
    .data     (data),
    .bp       (bp),
    .odd_mode (ODD_MODE),
    .err      (err)
  );

  // result stage: one out_valid pulse per accepted word, S holds between words
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      S         <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        S <= err;
      end
    end
  end

  // statistics: clear wins over a concurrent error, counter saturates instead of wrapping
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_sticky <= 1'b0;
      err_cnt    <= '0;
    end else if (clr) begin
      err_sticky <= 1'b0;
      err_cnt    <= '0;
    end else if (in_valid && err) begin
      err_sticky <= 1'b1;
      if (err_cnt != CNT_MAX) begin
        err_cnt <= err_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_verificador_paridade.sv
// tb/tb_verificador_paridade.sv - self-checking bench for verificador_paridade
module tb_verificador_paridade;

  logic clk = 1'b0;
  logic rst_n, in_valid, b1, b2, b3, b4, b5, bp, clr;

  logic       s_e, ov_e, st_e;
  logic [7:0] cnt_e;
  logic       s_o, ov_o, st_o;
  logic [7:0] cnt_o;
  logic       s_s, ov_s, st_s;
  logic [1:0] cnt_s;

  int n_cmp  = 0;
  int n_fail = 0;

  // reference state per instance: 0 even/8-bit, 1 odd/8-bit, 2 even/2-bit
  bit m_s [3];
  bit m_ov[3];
  bit m_st[3];
  int m_cnt[3];
  int m_odd[3] = '{0, 1, 0};
  int m_max[3] = '{255, 255, 3};

  always #5 clk = ~clk;

  verificador_paridade #(.ODD_PARITY(0), .CNT_W(8)) u_even (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .b1(b1), .b2(b2), .b3(b3), .b4(b4), .b5(b5), .bp(bp), .clr(clr),
    .S(s_e), .out_valid(ov_e), .err_sticky(st_e), .err_cnt(cnt_e)
  );

  verificador_paridade #(.ODD_PARITY(1), .CNT_W(8)) u_odd (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .b1(b1), .b2(b2), .b3(b3), .b4(b4), .b5(b5), .bp(bp), .clr(clr),
    .S(s_o), .out_valid(ov_o), .err_sticky(st_o), .err_cnt(cnt_o)
  );

  verificador_paridade #(.ODD_PARITY(0), .CNT_W(2)) u_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .b1(b1), .b2(b2), .b3(b3), .b4(b4), .b5(b5), .bp(bp), .clr(clr),
    .S(s_s), .out_valid(ov_s), .err_sticky(st_s), .err_cnt(cnt_s)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("even.S",   int'(s_e),   int'(m_s[0]));
    chk("even.ov",  int'(ov_e),  int'(m_ov[0]));
    chk("even.st",  int'(st_e),  int'(m_st[0]));
    chk("even.cnt", int'(cnt_e), m_cnt[0]);
    chk("odd.S",    int'(s_o),   int'(m_s[1]));
    chk("odd.ov",   int'(ov_o),  int'(m_ov[1]));
    chk("odd.st",   int'(st_o),  int'(m_st[1]));
    chk("odd.cnt",  int'(cnt_o), m_cnt[1]);
    chk("sat.S",    int'(s_s),   int'(m_s[2]));
    chk("sat.ov",   int'(ov_s),  int'(m_ov[2]));
    chk("sat.st",   int'(st_s),  int'(m_st[2]));
    chk("sat.cnt",  int'(cnt_s), m_cnt[2]);
  endtask

  // apply one word {b1,b2,b3,b4,b5,bp} for one edge, advance the model, compare
  task automatic step(input bit v, input bit [5:0] w, input bit c, input bit r);
    bit e;
    in_valid = v;
    {b1, b2, b3, b4, b5, bp} = w;
    clr   = c;
    rst_n = r;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      e = (($countones(w) + m_odd[i]) % 2) == 1;
      if (!r) begin
        m_s[i] = 0; m_ov[i] = 0; m_st[i] = 0; m_cnt[i] = 0;
      end else begin
        m_ov[i] = v;
        if (v) m_s[i] = e;
        if (c) begin
          m_st[i] = 0; m_cnt[i] = 0;
        end else if (v && e) begin
          m_st[i]  = 1;
          m_cnt[i] = (m_cnt[i] + 1 > m_max[i]) ? m_max[i] : m_cnt[i] + 1;
        end
      end
    end
    check_all();
  endtask

  int sat_exp[5] = '{1, 2, 3, 3, 3};
  bit [5:0] rw;

  initial begin
    rst_n = 0; in_valid = 0; clr = 0;
    {b1, b2, b3, b4, b5, bp} = '0;

    // reset, also with in_valid and clr high
    step(0, 6'b000000, 0, 0);
    step(1, 6'b100000, 1, 0);
    chk("rst.S", int'(s_e), 0);
    chk("rst.cnt", int'(cnt_e), 0);

    // exhaustive sweep of all 64 words, back to back
    for (int k = 0; k < 64; k++) begin
      step(1, 6'(k), 0, 1);
      if (k == 0)  begin chk("ex000000.even", int'(s_e), 0); chk("ex000000.odd", int'(s_o), 1); end
      if (k == 1)  begin chk("ex000001.even", int'(s_e), 1); chk("ex000001.odd", int'(s_o), 0); end
      if (k == 3)  chk("ex000011.even", int'(s_e), 0);
      if (k == 62) chk("ex111110.even", int'(s_e), 1);
      if (k == 63) begin chk("ex111111.even", int'(s_e), 0); chk("ex111111.odd", int'(s_o), 1); end
    end
    chk("sweep.cnt", int'(cnt_e), 32);
    chk("sweep.st", int'(st_e), 1);
    chk("sweep.ov", int'(ov_e), 1);

    // clear alone
    step(0, 6'b000000, 1, 1);
    chk("clr.cnt", int'(cnt_e), 0);

    // valid gating: last S was 0 (word 000000 not applied; S from 111111 = 0)
    step(0, 6'b000001, 0, 1);
    chk("gate.ov", int'(ov_e), 0);
    chk("gate.cnt", int'(cnt_e), 0);
    step(1, 6'b000001, 0, 1);
    chk("gate.S", int'(s_e), 1);
    chk("gate.ov1", int'(ov_e), 1);

    // saturation on the 2-bit counter
    step(0, 6'b000000, 1, 1);
    for (int k = 0; k < 5; k++) begin
      step(1, 6'b100000, 0, 1);
      chk("sat.seq", int'(cnt_s), sat_exp[k]);
    end

    // clear beats a concurrent error
    step(1, 6'b100000, 1, 1);
    chk("clrpri.cnt", int'(cnt_s), 0);
    chk("clrpri.st", int'(st_s), 0);
    chk("clrpri.S", int'(s_s), 1);
    chk("clrpri.ov", int'(ov_s), 1);

    // reset in the middle of a stream
    step(1, 6'b100000, 0, 1);
    step(1, 6'b100000, 0, 0);
    chk("midrst.S", int'(s_e), 0);
    chk("midrst.ov", int'(ov_e), 0);
    chk("midrst.cnt", int'(cnt_e), 0);
    step(1, 6'b100000, 0, 1);
    chk("postrst.S", int'(s_e), 1);
    chk("postrst.cnt", int'(cnt_e), 1);

    // randomized traffic against the model
    for (int k = 0; k < 400; k++) begin
      rw = 6'($urandom_range(0, 63));
      step($urandom_range(0, 3) != 0, rw,
           $urandom_range(0, 19) == 0, $urandom_range(0, 49) != 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
